router_pkt_fifo: RTL and testbench

Parametrised, packet-aware FIFO for the 1x3 router output channels; one instance per output port, between the router FSM/register stage (write side) and the destination read interface. It stores a first-byte flag beside each data word. On the read side it tracks the packet length decoded from the header, so it reports packet boundaries. Compared with the fixed 8x16 channel FIFO, it adds configurable width and depth, occupancy level, almost-full, write-drop reporting and packet-done signalling.

---
 rtl/router_pkg.sv | 13 +
 rtl/router_fifo_mem.sv | 25 ++
 rtl/router_pkt_fifo.sv | 129 ++++++++++++
 tb/tb_router_pkt_fifo.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router constants and header field helpers
package router_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int ADDR_W     = 2;
    localparam int LEN_LSB    = ADDR_W;

    // Header layout: length above the destination address bits
    function automatic logic [31:0] hdr_len(input logic [31:0] hdr);
        return hdr >> LEN_LSB;
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// rtl/router_fifo_mem.sv - simple dual-port register array, sync write, indexed read
module router_fifo_mem #(
    parameter int W     = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Storage write; contents survive both resets
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/router_pkt_fifo.sv
// rtl/router_pkt_fifo.sv - packet-aware output channel FIFO with level and packet tracking
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     soft_rst,
    input  logic                     wr_en,
    input  logic                     lfd_state,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        data_out,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     pkt_busy,
    output logic                     pkt_done,
    output logic                     wr_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = DATA_W - 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;

    logic [DATA_W:0]   mem_rdata;
    logic              wr_acc;
    logic              rd_acc;
    logic [CW-1:0]     cnt_load;

    router_fifo_mem #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc && !soft_rst),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata ({lfd_state, data_in}),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    // Flags come straight from the registered pointers; wrap bit separates full from empty
    assign level       = wr_ptr_q - rd_ptr_q;
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign almost_full = (level >= PW'(AFULL_TH));

    assign wr_acc   = wr_en && !full;
    assign rd_acc   = rd_en && !empty;
    // Header length plus the trailing parity word
    assign cnt_load = CW'(hdr_len(32'(mem_rdata[DATA_W-1:0])) + 32'd1);

    // Next-state: soft reset flushes, otherwise advance pointers and packet tracking
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        drop_d   = 1'b0;
        if (soft_rst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            dout_d   = '0;
            cnt_d    = '0;
            busy_d   = 1'b0;
        end else begin
            drop_d = wr_en && full;
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                dout_d   = mem_rdata[DATA_W-1:0];
                if (mem_rdata[DATA_W]) begin
                    cnt_d  = cnt_load;
                    busy_d = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
        end
    end

    assign data_out = dout_q;
    assign pkt_busy = busy_q;
    assign pkt_done = done_q;
    assign wr_drop  = drop_q;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb/tb_router_pkt_fifo.sv - scoreboard bench for router_pkt_fifo
module tb_router_pkt_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFTH  = DEPTH - 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          soft_rst = 1'b0;
    logic          wr_en = 1'b0;
    logic          lfd_state = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_out;
    logic          empty, full, almost_full, pkt_busy, pkt_done, wr_drop;
    logic [4:0]    level;

    int checks = 0;
    int errors = 0;

    router_pkt_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_TH(AFTH)) dut (
        .clk(clk), .rstn(rstn), .soft_rst(soft_rst), .wr_en(wr_en),
        .lfd_state(lfd_state), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .empty(empty), .full(full),
        .almost_full(almost_full), .level(level), .pkt_busy(pkt_busy),
        .pkt_done(pkt_done), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {flag,data} words plus words-left-in-packet
    typedef struct {
        logic [DW-1:0] d;
        bit            done;
        bit            busy;
    } exp_t;

    logic [DW:0]   m_q[$];
    exp_t          exp_q[$];
    int            m_rem = 0;
    bit            m_busy = 0;
    bit            m_done = 0;
    bit            m_drop = 0;
    logic [DW-1:0] m_dout = '0;
    bit            rd_fired = 0;

    initial forever begin
        bit          was_full;
        bit          was_empty;
        logic [DW:0] w;
        @(posedge clk or negedge rstn);
        if (!rstn || soft_rst) begin
            m_q.delete();
            exp_q.delete();
            m_rem = 0; m_busy = 0; m_done = 0; m_drop = 0;
            m_dout = '0; rd_fired = 0;
        end else begin
            was_full  = (m_q.size() == DEPTH);
            was_empty = (m_q.size() == 0);
            m_drop    = wr_en && was_full;
            m_done    = 0;
            rd_fired  = 0;
            if (rd_en && !was_empty) begin
                w = m_q.pop_front();
                m_dout = w[DW-1:0];
                if (w[DW]) begin
                    m_rem  = int'(w[DW-1:2]) + 1;
                    m_busy = 1;
                end else if (m_rem > 0) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
                exp_q.push_back('{m_dout, m_done, m_busy});
                rd_fired = 1;
            end
            if (wr_en && !was_full) m_q.push_back({lfd_state, data_in});
        end
    end

    // Monitor: status every cycle, read results popped from the scoreboard
    initial forever begin
        exp_t e;
        @(negedge clk);
        chk("level", int'(level), m_q.size());
        chk("empty", int'(empty), int'(m_q.size() == 0));
        chk("full", int'(full), int'(m_q.size() == DEPTH));
        chk("almost_full", int'(almost_full), int'(m_q.size() >= AFTH));
        chk("wr_drop", int'(wr_drop), int'(m_drop));
        if (rd_fired) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_underflow", 0, 1);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", int'(data_out), int'(e.d));
                chk("rd_pkt_done", int'(pkt_done), int'(e.done));
                chk("rd_pkt_busy", int'(pkt_busy), int'(e.busy));
            end
        end else begin
            chk("hold_data", int'(data_out), int'(m_dout));
            chk("idle_pkt_done", int'(pkt_done), 0);
            chk("idle_pkt_busy", int'(pkt_busy), int'(m_busy));
        end
    end

    task automatic drive(input bit w, input bit l, input logic [DW-1:0] d, input bit r, input bit s = 0);
        @(negedge clk);
        wr_en = w; lfd_state = l; data_in = d; rd_en = r; soft_rst = s;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data_out"}, int'(data_out), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_almost_full"}, int'(almost_full), 0);
        chk({tag, "_level"}, int'(level), 0);
        chk({tag, "_pkt_busy"}, int'(pkt_busy), 0);
        chk({tag, "_pkt_done"}, int'(pkt_done), 0);
        chk({tag, "_wr_drop"}, int'(wr_drop), 0);
    endtask

    initial begin
        logic [DW-1:0] par;
        logic [DW-1:0] v;
        logic [DW:0]   pk[$];
        int            wi;
        int            ri;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rstn = 1'b1;
        idle(2);

        // Fill with one 16-word packet, then one write into a full FIFO
        par = 8'h39;
        drive(1, 1, 8'h39, 0);
        for (int i = 0; i < 14; i++) begin
            v = DW'($urandom);
            par ^= v;
            drive(1, 0, v, 0);
        end
        drive(1, 0, par, 0);
        drive(1, 0, 8'hAA, 0);
        idle(2);

        // Drain, plus one read against an empty FIFO
        for (int i = 0; i < DEPTH + 1; i++) drive(0, 0, '0, 1);
        idle(2);

        // Three packets through a wrapped FIFO with level held by concurrent traffic
        pk.delete();
        for (int p = 0; p < 3; p++) begin
            pk.push_back({1'b1, 8'h19});
            for (int i = 0; i < 7; i++) pk.push_back({1'b0, DW'($urandom)});
        end
        wi = 0;
        ri = 0;
        while (wi < 5) begin
            drive(1, pk[wi][DW], pk[wi][DW-1:0], 0);
            wi++;
        end
        while (wi < pk.size()) begin
            drive(1, pk[wi][DW], pk[wi][DW-1:0], 1);
            wi++;
            ri++;
        end
        while (ri < pk.size()) begin
            drive(0, 0, '0, 1);
            ri++;
        end
        idle(2);

        // Zero-length header followed directly by parity
        drive(1, 1, 8'h02, 0);
        drive(1, 0, 8'h5A, 0);
        drive(0, 0, '0, 1);
        drive(0, 0, '0, 1);
        idle(2);

        // Soft reset mid-packet with a concurrent write
        drive(1, 1, 8'h19, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, DW'($urandom), 0);
        drive(0, 0, '0, 1);
        drive(0, 0, '0, 1);
        drive(1, 0, 8'hC3, 0, 1);
        drive(0, 0, '0, 0);
        #1;
        chk("soft_rst_empty", int'(empty), 1);
        chk("soft_rst_level", int'(level), 0);
        chk("soft_rst_busy", int'(pkt_busy), 0);
        chk("soft_rst_data_out", int'(data_out), 0);
        idle(2);

        // Random traffic: write-heavy then read-heavy phases, occasional flush
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 150; i++) begin
                drive(($urandom_range(0, 99) < ((ph % 2 == 0) ? 75 : 30)),
                      ($urandom_range(0, 7) == 0),
                      DW'($urandom),
                      ($urandom_range(0, 99) < ((ph % 2 == 0) ? 30 : 75)),
                      ($urandom_range(0, 199) == 0));
            end
        end
        idle(2);

        // Asynchronous reset in the middle of a write burst
        for (int i = 0; i < 5; i++) drive(1, (i == 0), DW'($urandom), 0);
        drive(1, 0, DW'($urandom), 0);
        #3 rstn = 1'b0;
        #1 chk_reset_outputs("async_rst");
        drive(0, 0, '0, 0);
        @(negedge clk);
        rstn = 1'b1;
        idle(2);
        chk("post_reset_level", int'(level), 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
